gf_pow_ctrl: RTL and testbench

Sequential GF(2^8) exponentiation controller that time-shares a single instance of the team's combinational multiplier `galoisadd(a,b,i,out)` to compute base^exp mod the field polynomial. It also serves as the field-inverse engine, via base^254. It sits between register-mapped operand logic and the multiplier: it latches one request, sequences 16 multiplier cycles through left-to-right square-and-multiply, and returns a result with a one-cycle done strobe.

---
 rtl/gf_pow_ctrl_if.sv | 29 ++
 rtl/gf_pow_ctrl.sv | 131 +++++++++++++
 tb/tb_gf_pow_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gf_pow_ctrl_if.sv
// gf_pow_ctrl_if: request/response bundle between operand logic and gf_pow_ctrl.
//   start  : request strobe (sampled only while the controller is idle)
//   inv    : inverse mode, forces exponent 254
//   base   : 8-bit operand
//   exp    : 8-bit exponent
//   poly   : low byte of the field polynomial (x^8 implicit)
//   busy   : high during the 16 compute cycles
//   done   : one-cycle strobe when result becomes valid
//   result : base^exp, held until the next accepted request
interface gf_pow_ctrl_if;
  logic       start;
  logic       inv;
  logic [7:0] base;
  logic [7:0] exp;
  logic [7:0] poly;
  logic       busy;
  logic       done;
  logic [7:0] result;

  modport master (
    output start, inv, base, exp, poly,
    input  busy, done, result
  );

  modport slave (
    input  start, inv, base, exp, poly,
    output busy, done, result
  );
endinterface

// File: rtl/gf_pow_ctrl.sv
// gf_pow_ctrl: sequential GF(2^8) exponentiation (base^exp mod poly) using one
// shared combinational multiplier and left-to-right square-and-multiply.
// Inverse mode computes base^254. Fixed 17-cycle request-to-result latency.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : gf_pow_ctrl_if.slave (start/inv/base/exp/poly in, busy/done/result out)
module gf_pow_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  gf_pow_ctrl_if.slave  bus
);

  localparam int unsigned W       = 8;
  localparam int unsigned KW      = 3;
  localparam int unsigned INV_EXP = 254;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SQR  = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state;
  logic [W-1:0]  r;
  logic [W-1:0]  base_q;
  logic [W-1:0]  exp_q;
  logic [W-1:0]  poly_q;
  logic [KW-1:0] k;
  logic          busy_q;
  logic          done_q;
  logic [W-1:0]  result_q;

  logic [W-1:0]  mul_b;
  logic [W-1:0]  mul_out;

  // Squaring uses (r, r); the multiply step uses (r, base_q).
  assign mul_b = (state == S_MUL) ? base_q : r;

  galoisadd u_mul (
    .a   (r),
    .b   (mul_b),
    .i   (poly_q),
    .out (mul_out)
  );

  // Control FSM with all datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      r        <= '0;
      base_q   <= '0;
      exp_q    <= '0;
      poly_q   <= '0;
      k        <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            base_q <= bus.base;
            poly_q <= bus.poly;
            exp_q  <= bus.inv ? W'(INV_EXP) : bus.exp;
            r      <= W'(1);
            k      <= KW'(7);
            busy_q <= 1'b1;
            state  <= S_SQR;
          end
        end
        S_SQR: begin
          r     <= mul_out;
          state <= S_MUL;
        end
        S_MUL: begin
          // The cycle is spent even for a zero bit so latency is data-independent.
          if (exp_q[k]) begin
            r <= mul_out;
          end
          if (k == KW'(0)) begin
            busy_q <= 1'b0;
            state  <= S_DONE;
          end else begin
            k     <= k - KW'(1);
            state <= S_SQR;
          end
        end
        S_DONE: begin
          result_q <= r;
          done_q   <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// galoisadd: combinational GF(2^8) multiply, out = a*b mod (x^8 + i).
module galoisadd (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] i,
  output logic [7:0] out
);

  // Shift-and-add: accumulate a*x^j for each set bit of b, reducing as we shift.
  always_comb begin
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int j = 0; j < 8; j++) begin
      if (b[j]) begin
        acc = acc ^ sh;
      end
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? i : 8'h00);
    end
    out = acc;
  end

endmodule

// File: tb/tb_gf_pow_ctrl.sv
// tb_gf_pow_ctrl: directed checks of gf_pow_ctrl (reset, latency, arithmetic,
// inverse mode, boundary exponents, ignored starts, async abort, inverse sweep).
module tb_gf_pow_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  gf_pow_ctrl_if ifc ();

  gf_pow_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference multiply, MSB-first Horner form.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] p);
    logic [7:0] acc;
    acc = 8'h00;
    for (int j = 7; j >= 0; j--) begin
      acc = acc[7] ? ({acc[6:0], 1'b0} ^ p) : {acc[6:0], 1'b0};
      if (a[j]) acc = acc ^ b;
    end
    return acc;
  endfunction

  // Issue one request and wait (bounded) for done; lat = -1 on timeout.
  task automatic do_op(input logic [7:0] b, input logic [7:0] e, input logic iv,
                       input logic [7:0] p, output logic [7:0] res,
                       output int lat, output int busy_cycles, output int overlap);
    @(negedge clk);
    ifc.base  = b;
    ifc.exp   = e;
    ifc.inv   = iv;
    ifc.poly  = p;
    ifc.start = 1'b1;
    @(posedge clk);
    #1;
    ifc.start   = 1'b0;
    lat         = 0;
    busy_cycles = ifc.busy ? 1 : 0;
    overlap     = 0;
    while (!ifc.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (ifc.busy) busy_cycles++;
      if (ifc.busy && ifc.done) overlap++;
    end
    if (!ifc.done) lat = -1;
    res = ifc.result;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    ifc.start = 1'b0;
    ifc.inv   = 1'b0;
    ifc.base  = 8'h00;
    ifc.exp   = 8'h00;
    ifc.poly  = 8'h1B;
    #12;
    checks++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.result !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b result=%h expected 0 0 00",
               ifc.busy, ifc.done, ifc.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", ifc.busy, ifc.done);
    end
  endtask

  task automatic test_square();
    logic [7:0] res;
    int lat, bc, ov;
    do_op(8'h57, 8'h02, 1'b0, 8'h1B, res, lat, bc, ov);
    checks++;
    if (res !== 8'hA5) begin
      errors++;
      $display("FAIL square_result: got %h expected a5", res);
    end
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL square_latency: got %0d expected 17", lat);
    end
    checks++;
    if (bc !== 16) begin
      errors++;
      $display("FAIL square_busy_cycles: got %0d expected 16", bc);
    end
    checks++;
    if (ov !== 0) begin
      errors++;
      $display("FAIL busy_done_overlap: got %0d expected 0", ov);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ifc.done !== 1'b0 || ifc.busy !== 1'b0 || ifc.result !== 8'hA5) begin
      errors++;
      $display("FAIL done_one_cycle: done=%b busy=%b result=%h expected 0 0 a5",
               ifc.done, ifc.busy, ifc.result);
    end
  endtask

  task automatic test_inverse_and_boundaries();
    logic [7:0] vb [8] = '{8'h53, 8'h01, 8'h00, 8'h57, 8'h00, 8'h83, 8'h00, 8'h53};
    logic [7:0] ve [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h05, 8'h02};
    logic       vi [8] = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
    logic [7:0] vx [8] = '{8'hCA, 8'h01, 8'h00, 8'h01, 8'h01, 8'h83, 8'h00, 8'hCA};
    logic [7:0] res;
    int lat, bc, ov;
    for (int n = 0; n < 8; n++) begin
      do_op(vb[n], ve[n], vi[n], 8'h1B, res, lat, bc, ov);
      checks++;
      if (res !== vx[n] || lat !== 17) begin
        errors++;
        $display("FAIL vector%0d base=%h exp=%h inv=%b: got %h lat %0d expected %h lat 17",
                 n, vb[n], ve[n], vi[n], res, lat, vx[n]);
      end
    end
  endtask

  task automatic test_ignored_start();
    logic [7:0] res;
    int lat, bc, ov;
    @(negedge clk);
    ifc.base  = 8'h53;
    ifc.exp   = 8'h00;
    ifc.inv   = 1'b1;
    ifc.poly  = 8'h1B;
    ifc.start = 1'b1;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(negedge clk);
      // Disturbing operands and stray starts while the request is in flight.
      ifc.base  = 8'h02;
      ifc.exp   = 8'h03;
      ifc.inv   = 1'b0;
      ifc.poly  = 8'h1D;
      ifc.start = (cyc == 5 || cyc == 17);
      @(posedge clk);
      #1;
      ifc.start = 1'b0;
    end
    checks++;
    if (ifc.done !== 1'b1 || ifc.result !== 8'hCA) begin
      errors++;
      $display("FAIL ignore_start_result: done=%b result=%h expected 1 ca", ifc.done, ifc.result);
    end
    do_op(8'h57, 8'h02, 1'b0, 8'h1B, res, lat, bc, ov);
    checks++;
    if (res !== 8'hA5 || lat !== 17) begin
      errors++;
      $display("FAIL accept_at_e18: got %h lat %0d expected a5 lat 17", res, lat);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] res;
    int lat, bc, ov, seen;
    @(negedge clk);
    ifc.base  = 8'h53;
    ifc.inv   = 1'b1;
    ifc.poly  = 8'h1B;
    ifc.start = 1'b1;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.result !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b result=%h expected 0 0 00",
               ifc.busy, ifc.done, ifc.result);
    end
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (ifc.done) seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (ifc.done || ifc.busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d activity cycles expected 0", seen);
    end
    do_op(8'h53, 8'h00, 1'b1, 8'h1B, res, lat, bc, ov);
    checks++;
    if (res !== 8'hCA || lat !== 17) begin
      errors++;
      $display("FAIL after_reset_inverse: got %h lat %0d expected ca lat 17", res, lat);
    end
  endtask

  task automatic test_inverse_sweep();
    logic [7:0] res;
    logic [7:0] prod;
    int lat, bc, ov;
    for (int b = 0; b < 256; b++) begin
      do_op(8'(b), 8'(b * 7), 1'b1, 8'h1B, res, lat, bc, ov);
      prod = gmul(8'(b), res, 8'h1B);
      checks++;
      if (lat !== 17 || (b == 0 && res !== 8'h00) || (b != 0 && prod !== 8'h01)) begin
        errors++;
        $display("FAIL sweep base=%h: inv=%h product=%h lat %0d expected product 01 lat 17",
                 8'(b), res, prod, lat);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_square();
    test_inverse_and_boundaries();
    test_ignored_start();
    test_async_reset();
    test_inverse_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
